// File: rtl/jelly_denorm_float_mul_mc.sv
// rtl/jelly_denorm_float_mul_mc.sv - multi-lane denorm fixed x float multiplier, 3-stage pipeline
// Optional macro JELLY_DENORM_FLOAT_MUL_MC_ROUND_EN: round-half-away-from-zero on the right shift.
module jelly_denorm_float_mul_mc #(
   parameter int CHANNELS            = 2,
   parameter int S_DENORM_EXP_WIDTH  = 8,
   parameter int S_DENORM_INT_WIDTH  = 17,
   parameter int S_DENORM_FRAC_WIDTH = 8,
   parameter int S_FLOAT_EXP_WIDTH   = 8,
   parameter int S_FLOAT_FRAC_WIDTH  = 16,
   parameter int M_DENORM_EXP_WIDTH  = 8,
   parameter int M_DENORM_INT_WIDTH  = 17,
   parameter int M_DENORM_FRAC_WIDTH = 8,
   parameter int USER_WIDTH          = 0,
   localparam int USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1,
   localparam int S_FIXED   = S_DENORM_INT_WIDTH + S_DENORM_FRAC_WIDTH,
   localparam int M_FIXED   = M_DENORM_INT_WIDTH + M_DENORM_FRAC_WIDTH,
   localparam int FLOAT_W   = 1 + S_FLOAT_EXP_WIDTH + S_FLOAT_FRAC_WIDTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cke,
   input  logic [USER_BITS-1:0]            s_user,
   input  logic [S_DENORM_EXP_WIDTH-1:0]   s_denorm_exp,
   input  logic [CHANNELS*S_FIXED-1:0]     s_denorm_fixed,
   input  logic [FLOAT_W-1:0]              s_float,
   input  logic                            s_valid,
   output logic                            s_ready,
   output logic [USER_BITS-1:0]            m_user,
   output logic [M_DENORM_EXP_WIDTH-1:0]   m_denorm_exp,
   output logic [CHANNELS*M_FIXED-1:0]     m_denorm_fixed,
   output logic                            m_valid,
   input  logic                            m_ready
);

   localparam int FFW   = S_FLOAT_FRAC_WIDTH;
   localparam int FEW   = S_FLOAT_EXP_WIDTH;
   localparam int MEW   = M_DENORM_EXP_WIDTH;
   localparam int PW    = S_FIXED + FFW + 2;
   localparam int D     = S_DENORM_FRAC_WIDTH + FFW - M_DENORM_FRAC_WIDTH;
   localparam int DR    = (D > 0) ? D : 0;
   localparam int DL    = (D < 0) ? -D : 0;
   localparam int XW0   = PW + DL + 1;
   localparam int XW    = (XW0 > M_FIXED) ? XW0 : M_FIXED + 1;
   localparam int S_OFF = (1 << (S_DENORM_EXP_WIDTH - 1)) - 1;
   localparam int F_OFF = (1 << (FEW - 1)) - 1;
   localparam int M_OFF = (1 << (MEW - 1)) - 1;
   localparam int OFFS  = S_OFF + F_OFF - M_OFF;
`ifdef JELLY_DENORM_FLOAT_MUL_MC_ROUND_EN
   localparam logic [XW-1:0] RND = (DR > 0) ? (XW'(1) << ((DR > 0) ? DR - 1 : 0)) : '0;
`endif

   logic                               w_en;
   logic                               r0_valid, r1_valid, r2_valid;
   logic [USER_BITS-1:0]               r0_user, r1_user, r2_user;
   logic [S_DENORM_EXP_WIDTH-1:0]      r0_exp;
   logic [CHANNELS-1:0][S_FIXED-1:0]   r0_fixed;
   logic [FLOAT_W-1:0]                 r0_float;
   logic [MEW-1:0]                     r1_exp, r2_exp;
   logic                               r1_zero;
   logic [CHANNELS-1:0][PW-1:0]        r1_prod;
   logic [CHANNELS-1:0][M_FIXED-1:0]   r2_fixed;

   logic                               w_f_sign;
   logic [FEW-1:0]                     w_f_exp;
   logic [FFW-1:0]                     w_f_frac;
   logic [FFW+1:0]                     w_f_mag;
   logic signed [FFW+1:0]              w_f_int;
   logic                               w_zero;
   logic [MEW-1:0]                     w_exp;
   logic [CHANNELS-1:0][PW-1:0]        w_prod;
   logic [CHANNELS-1:0][M_FIXED-1:0]   w_out;

   // the whole pipeline moves as one; a stalled output stalls every stage
   assign w_en    = cke && (!r2_valid || m_ready);
   assign s_ready = w_en;

   assign w_f_sign = r0_float[FLOAT_W-1];
   assign w_f_exp  = r0_float[FFW +: FEW];
   assign w_f_frac = r0_float[FFW-1:0];
   assign w_f_mag  = {1'b0, (w_f_exp != '0), w_f_frac};
   assign w_f_int  = w_f_sign ? -$signed(w_f_mag) : $signed(w_f_mag);
   assign w_zero   = (w_f_exp == '0) && (w_f_frac == '0);
   assign w_exp    = MEW'(r0_exp) + MEW'(w_f_exp) - MEW'(OFFS);

   always_comb begin
      w_prod = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_prod[i] = PW'($signed(r0_fixed[i])) * PW'(w_f_int);
      end
   end

   always_comb begin
      logic signed [XW-1:0] v_ext;
      logic signed [XW-1:0] v_res;
`ifdef JELLY_DENORM_FLOAT_MUL_MC_ROUND_EN
      logic                 v_neg;
      logic [XW-1:0]        v_mag;
`endif
      w_out = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         v_ext = XW'($signed(r1_prod[i]));
         if (DR > 0) begin
`ifdef JELLY_DENORM_FLOAT_MUL_MC_ROUND_EN
            v_neg = v_ext[XW-1];
            v_mag = v_neg ? XW'(-v_ext) : XW'(v_ext);
            v_mag = (v_mag + RND) >> DR;
            v_res = v_neg ? -$signed(v_mag) : $signed(v_mag);
`else
            v_res = v_ext >>> DR;
`endif
         end else begin
            v_res = v_ext <<< DL;
         end
         w_out[i] = r1_zero ? '0 : v_res[M_FIXED-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r0_valid <= 1'b0;
         r1_valid <= 1'b0;
         r2_valid <= 1'b0;
      end else if (w_en) begin
         r0_valid <= s_valid;
         r1_valid <= r0_valid;
         r2_valid <= r1_valid;
      end
   end

   // data registers carry no reset; they are qualified by the valid bits
   always_ff @(posedge clk) begin
      if (w_en) begin
         r0_user  <= s_user;
         r0_exp   <= s_denorm_exp;
         r0_fixed <= s_denorm_fixed;
         r0_float <= s_float;
         r1_user  <= r0_user;
         r1_exp   <= w_exp;
         r1_zero  <= w_zero;
         r1_prod  <= w_prod;
         r2_user  <= r1_user;
         r2_exp   <= r1_zero ? '0 : r1_exp;
         r2_fixed <= w_out;
      end
   end

   assign m_valid        = r2_valid;
   assign m_user         = r2_user;
   assign m_denorm_exp   = r2_exp;
   assign m_denorm_fixed = r2_fixed;

endmodule

// File: tb/tb_jelly_denorm_float_mul_mc.sv
// tb/tb_jelly_denorm_float_mul_mc.sv - directed vectors and stream sequences for jelly_denorm_float_mul_mc
module tb_jelly_denorm_float_mul_mc;

`ifdef JELLY_DENORM_FLOAT_MUL_MC_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        cke;
   logic [0:0]  s_user;
   logic [7:0]  s_denorm_exp;
   logic [49:0] s_denorm_fixed;
   logic [24:0] s_float;
   logic        s_valid;
   logic        s_ready;
   logic [0:0]  m_user;
   logic [7:0]  m_denorm_exp;
   logic [49:0] m_denorm_fixed;
   logic        m_valid;
   logic        m_ready;

   int total = 0;
   int bad   = 0;

   jelly_denorm_float_mul_mc dut (
      .clk(clk), .reset(reset), .cke(cke),
      .s_user(s_user), .s_denorm_exp(s_denorm_exp), .s_denorm_fixed(s_denorm_fixed),
      .s_float(s_float), .s_valid(s_valid), .s_ready(s_ready),
      .m_user(m_user), .m_denorm_exp(m_denorm_exp), .m_denorm_fixed(m_denorm_fixed),
      .m_valid(m_valid), .m_ready(m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [24:0] f0, f1, flt;
      logic [7:0]  sexp;
      logic [24:0] e0, e1;
      logic [7:0]  eexp;
   } vec_t;

   typedef struct {
      logic [0:0]  user;
      logic [7:0]  eexp;
      logic [49:0] fixed;
   } exp_t;

   vec_t vt[9];

   function automatic logic [24:0] fl(input logic s, input logic [7:0] e, input logic [15:0] f);
      return {s, e, f};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      int k;
      bit got;
      @(negedge clk);
      s_denorm_fixed = {v.f1, v.f0};
      s_float        = v.flt;
      s_denorm_exp   = v.sexp;
      s_user         = 1'b1;
      s_valid        = 1'b1;
      m_ready        = 1'b1;
      #1;
      check($sformatf("vec%0d_s_ready", idx), 64'(s_ready), 64'd1);
      @(posedge clk);
      k   = 0;
      got = 1'b0;
      while (k < 10 && !got) begin
         @(negedge clk);
         s_valid = 1'b0;
         k++;
         if (m_valid) got = 1'b1;
      end
      check($sformatf("vec%0d_latency", idx), 64'(k), 64'd3);
      check($sformatf("vec%0d_out", idx), {6'd0, m_denorm_exp, m_denorm_fixed},
            {6'd0, v.eexp, v.e1, v.e0});
      @(negedge clk);
      check($sformatf("vec%0d_drain", idx), 64'(m_valid), 64'd0);
   endtask

   function automatic exp_t beat_exp(input int i);
      exp_t e;
      logic [24:0] a, b;
      a = 25'(i * 256);
      b = 25'(-i);
      e.user  = 1'(i);
      e.eexp  = 8'(100 + i);
      e.fixed = {b, a};
      return e;
   endfunction

   task automatic drive_beat(input int i);
      logic [24:0] a, b;
      a = 25'(i * 256);
      b = 25'(-i);
      s_denorm_fixed = {b, a};
      s_float        = fl(1'b0, 8'd127, 16'h0000);
      s_denorm_exp   = 8'(100 + i);
      s_user         = 1'(i);
      s_valid        = 1'b1;
   endtask

   // mode 0: m_ready 1-0-0-1; mode 1: cke low for 4 cycles; mode 2: full rate
   task automatic run_stream(input int n, input int mode);
      exp_t q[$];
      exp_t h;
      int   sent = 0;
      int   recv = 0;
      int   cyc  = 0;
      bit   in_x, out_x;
      while (recv < n && cyc < 400) begin
         @(negedge clk);
         if (m_valid) begin
            if (q.size() == 0) begin
               check($sformatf("m%0d_unexpected_beat", mode), 64'd1, 64'd0);
            end else begin
               h = q[0];
               check($sformatf("m%0d_beat%0d", mode, recv), {5'd0, m_user, m_denorm_exp, m_denorm_fixed},
                     {5'd0, h.user, h.eexp, h.fixed});
            end
         end
         if (mode == 1 && cyc >= 7 && cyc <= 10)
            check($sformatf("m1_frozen_valid_c%0d", cyc), 64'(m_valid), 64'd1);
         m_ready = (mode == 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         cke     = (mode == 1) ? !(cyc >= 6 && cyc < 10) : 1'b1;
         if (sent < n) drive_beat(sent);
         else          s_valid = 1'b0;
         #1;
         if (mode == 0)
            check("m0_s_ready", 64'(s_ready), 64'(cke && (!m_valid || m_ready)));
         in_x  = s_valid && s_ready;
         out_x = m_valid && m_ready && cke;
         @(posedge clk);
         if (out_x) begin
            void'(q.pop_front());
            recv++;
         end
         if (in_x) begin
            q.push_back(beat_exp(sent));
            sent++;
         end
         cyc++;
      end
      check($sformatf("m%0d_recv_count", mode), 64'(recv), 64'(n));
      if (mode == 2) check("m2_cycles", 64'(cyc), 64'(n + 3));
      @(negedge clk);
      s_valid = 1'b0;
      cke     = 1'b1;
      check($sformatf("m%0d_idle_after", mode), 64'(m_valid), 64'd0);
   endtask

   initial begin
      vt[0] = '{25'h100, -25'd512, fl(1'b0, 8'd127, 16'h8000), 8'd127, 25'h180, -25'd768, 8'd127};
      vt[1] = '{25'h123, -25'd5, fl(1'b0, 8'd0, 16'h0000), 8'd130, 25'd0, 25'd0, 8'd0};
      vt[2] = '{25'h100, 25'h50, fl(1'b1, 8'd127, 16'h0000), 8'd10, -25'd256, -25'd80, 8'd10};
      vt[3] = '{25'h001, 25'h000, fl(1'b0, 8'd126, 16'h0000), 8'd127, 25'h001, 25'h000, 8'd126};
      vt[4] = '{25'h001, -25'd1, fl(1'b0, 8'd126, 16'h8000), 8'd127,
                RND ? 25'd2 : 25'd1, -25'd2, 8'd126};
      vt[5] = '{-25'd1, 25'd3, fl(1'b0, 8'd127, 16'h4000), 8'd127,
                RND ? -25'd1 : -25'd2, RND ? 25'd4 : 25'd3, 8'd127};
      vt[6] = '{25'h200, -25'd512, fl(1'b0, 8'd0, 16'h8000), 8'd200, 25'h100, -25'd256, 8'd73};
      vt[7] = '{25'h0FFFFFF, 25'h0, fl(1'b0, 8'd127, 16'hFFFF), 8'd5, 25'h1FFFEFE, 25'h0, 8'd5};
      vt[8] = '{25'd7, -25'd7, fl(1'b0, 8'd1, 16'h0000), 8'd0, 25'd7, -25'd7, 8'd130};

      reset          = 1'b1;
      cke            = 1'b1;
      s_valid        = 1'b0;
      m_ready        = 1'b1;
      s_user         = '0;
      s_denorm_exp   = '0;
      s_denorm_fixed = '0;
      s_float        = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_m_valid", 64'(m_valid), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) apply_vec(vt[i], i);

      // fill the pipe with three beats, then reset with cke low
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_beat(50 + i);
         @(posedge clk);
         @(negedge clk);
      end
      check("rst_pipe_full", 64'(m_valid), 64'd1);
      s_valid = 1'b0;
      reset   = 1'b1;
      cke     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_flush", 64'(m_valid), 64'd0);
      reset   = 1'b0;
      cke     = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("rst_no_stale%0d", i), 64'(m_valid), 64'd0);
      end
      apply_vec(vt[0], 100);

      run_stream(20, 0);
      run_stream(20, 1);
      run_stream(12, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
